// File: rtl/game_progress.sv
// Game-state tracker: inning/half, per-team run totals and end-of-game detection.
// Every output is a flop, so there is no combinational path from the pulses to the display.
module game_progress #(
  parameter int INNINGS     = 9,
  parameter int MAX_INNINGS = 12,
  parameter int SCORE_MAX   = 99
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       change_pulse,
  input  logic [3:0] run_pulse,
  output logic [3:0] inning,
  output logic       bottom,
  output logic [6:0] score0,
  output logic [6:0] score1,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       play_en
);

  localparam logic [3:0] REG_INNING = 4'(INNINGS);
  localparam logic [3:0] MAX_INNING = 4'(MAX_INNINGS);
  localparam logic [7:0] SAT_WIDE   = 8'(SCORE_MAX);
  localparam logic [6:0] SAT_SCORE  = 7'(SCORE_MAX);

  typedef enum logic [1:0] {
    TOP    = 2'd0,
    BOTTOM = 2'd1,
    OVER   = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [3:0] inning_next;
  logic       bottom_next;
  logic [6:0] score0_next, score1_next;
  logic [1:0] winner_next;
  logic [2:0] run_count;
  logic [6:0] score0_credit, score1_credit;
  logic       late_inning;

  function automatic logic [6:0] add_sat(input logic [6:0] score, input logic [2:0] runs);
    logic [7:0] sum;
    sum = {1'b0, score} + {5'b0, runs};
    return (sum > SAT_WIDE) ? SAT_SCORE : sum[6:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= TOP;
      inning    <= 4'd1;
      bottom    <= 1'b0;
      score0    <= 7'd0;
      score1    <= 7'd0;
      winner    <= 2'b00;
      game_over <= 1'b0;
      play_en   <= 1'b1;
    end else begin
      state     <= state_next;
      inning    <= inning_next;
      bottom    <= bottom_next;
      score0    <= score0_next;
      score1    <= score1_next;
      winner    <= winner_next;
      game_over <= (state_next == OVER);
      play_en   <= (state_next != OVER);
    end
  end

  // Runs are credited first; every end-of-game test below uses the credited scores.
  always_comb begin
    run_count     = {2'b0, run_pulse[0]} + {2'b0, run_pulse[1]}
                  + {2'b0, run_pulse[2]} + {2'b0, run_pulse[3]};
    score0_credit = add_sat(score0, run_count);
    score1_credit = add_sat(score1, run_count);
    late_inning   = (inning >= REG_INNING);

    state_next  = state;
    inning_next = inning;
    bottom_next = bottom;
    score0_next = score0;
    score1_next = score1;
    winner_next = winner;

    case (state)
      TOP: begin
        score0_next = score0_credit;
        if (change_pulse) begin
          if (late_inning && (score1 > score0_credit)) begin
            state_next  = OVER;
            winner_next = 2'b10;
          end else begin
            state_next  = BOTTOM;
            bottom_next = 1'b1;
          end
        end
      end
      BOTTOM: begin
        score1_next = score1_credit;
        if (change_pulse) begin
          if (late_inning && (score0 != score1_credit)) begin
            state_next  = OVER;
            winner_next = (score1_credit > score0) ? 2'b10 : 2'b01;
          end else if (inning == MAX_INNING) begin
            state_next  = OVER;
            winner_next = 2'b11;
          end else begin
            state_next  = TOP;
            inning_next = inning + 4'd1;
            bottom_next = 1'b0;
          end
        end else if ((run_count != 3'd0) && late_inning && (score1_credit > score0)) begin
          state_next  = OVER;
          winner_next = 2'b10;
        end
      end
      default: begin
        state_next = OVER;
      end
    endcase
  end

endmodule
